// File: rtl/picosoc_mem_ctrl.sv
// rtl/picosoc_mem_ctrl.sv - CPU/loader arbiter and front-end for the on-chip firmware RAM
module picosoc_mem_ctrl #(
    parameter int unsigned WORDS     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    input  logic        ld_valid,
    input  logic        ld_we,
    input  logic [21:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    output logic [31:0] ld_rdata,

    output logic [3:0]  ram_wen,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int AW = $clog2(WORDS);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {GNT_CPU, GNT_LD} gnt_t;

    state_t      state;
    gnt_t        cur;
    gnt_t        last_grant;
    logic [21:0] addr_q;

    logic        cpu_hit;
    logic        cpu_req;
    logic        ld_req;
    logic        grant_cpu;
    logic        grant_ld;
    logic [21:0] cpu_word;
    logic [21:0] ld_word;
    logic        unused_bits;

    assign unused_bits = ^{mem_addr[1:0], ld_addr};

    // Requests are qualified by resetn so the RAM port is quiet while reset is held.
    always_comb begin
        cpu_hit   = mem_valid && (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
        cpu_req   = resetn && cpu_hit && (state == IDLE);
        ld_req    = resetn && ld_valid && (state == IDLE);
        grant_cpu = cpu_req && (!ld_req || (last_grant == GNT_LD));
        grant_ld  = ld_req && !grant_cpu;

        cpu_word           = '0;
        cpu_word[AW-1:0]   = mem_addr[AW+1:2];
        ld_word            = '0;
        ld_word[AW-1:0]    = ld_addr[AW-1:0];
    end

    always_comb begin
        ram_wen   = 4'h0;
        ram_wdata = 32'h0;
        ram_addr  = (state == RESP) ? addr_q : 22'h0;
        if (grant_cpu) begin
            ram_wen   = mem_wstrb;
            ram_wdata = mem_wdata;
            ram_addr  = cpu_word;
        end else if (grant_ld) begin
            ram_wen   = ld_we ? 4'hF : 4'h0;
            ram_wdata = ld_wdata;
            ram_addr  = ld_word;
        end
    end

    // Readies decode registered state only; rdata is gated to zero outside the pulse.
    assign mem_ready = (state == RESP) && (cur == GNT_CPU);
    assign ld_ready  = (state == RESP) && (cur == GNT_LD);
    assign mem_rdata = mem_ready ? ram_rdata : 32'h0;
    assign ld_rdata  = ld_ready  ? ram_rdata : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cur        <= GNT_LD;
            last_grant <= GNT_LD;
            addr_q     <= 22'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_ld) begin
                        state      <= RESP;
                        cur        <= grant_cpu ? GNT_CPU : GNT_LD;
                        last_grant <= grant_cpu ? GNT_CPU : GNT_LD;
                        addr_q     <= ram_addr;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
// tb/tb_picosoc_mem_ctrl.sv - scoreboard bench for picosoc_mem_ctrl with a behavioural RAM
module tb_picosoc_mem_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic        ld_we;
    logic [21:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic [31:0] ld_rdata;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_ld_ready;
    logic [31:0] m_ld_rdata;
    logic [3:0]  m_ram_wen;
    logic [21:0] m_ram_addr;
    logic [31:0] m_ram_wdata;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ram [0:255];
    logic [31:0] model [0:255];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    picosoc_mem_ctrl #(.WORDS(256), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ready(ld_ready), .ld_rdata(ld_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    picosoc_mem_ctrl #(.WORDS(256), .BASE_ADDR(32'h0001_0000)) u_miss (
        .clk(clk), .resetn(resetn),
        .mem_valid(m_valid), .mem_addr(m_addr), .mem_wdata(32'h5555_AAAA), .mem_wstrb(4'hF),
        .mem_ready(m_ready), .mem_rdata(m_rdata),
        .ld_valid(1'b0), .ld_we(1'b0), .ld_addr(22'h0), .ld_wdata(32'h0),
        .ld_ready(m_ld_ready), .ld_rdata(m_ld_rdata),
        .ram_wen(m_ram_wen), .ram_addr(m_ram_addr), .ram_wdata(m_ram_wdata), .ram_rdata(32'h0)
    );

    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [7:0] w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic cpu_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
        if (wstrb == 4'h0) sb.push_back(model[addr[9:2]]);
        else model_write(addr[9:2], wdata, wstrb);
        #1;
        chk("cpu_ram_addr", {10'h0, ram_addr}, {24'h0, addr[9:2]});
        chk("cpu_ram_wen", {28'h0, ram_wen}, {28'h0, wstrb});
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!mem_ready && n < 6);
        chk("cpu_latency", n, 1);
        chk("cpu_ld_quiet", {31'h0, ld_ready}, 32'h0);
        if (wstrb == 4'h0) begin
            exp = sb.pop_front();
            chk("cpu_rdata", mem_rdata, exp);
        end
        mem_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic ld_xfer(input logic [21:0] a, input logic we, input logic [31:0] wdata);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        ld_addr = a; ld_we = we; ld_wdata = wdata; ld_valid = 1'b1;
        if (!we) sb.push_back(model[a[7:0]]);
        else model_write(a[7:0], wdata, 4'hF);
        #1;
        chk("ld_ram_addr", {10'h0, ram_addr}, {10'h0, a});
        chk("ld_ram_wen", {28'h0, ram_wen}, we ? 32'hF : 32'h0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ld_ready && n < 6);
        chk("ld_latency", n, 1);
        if (!we) begin
            exp = sb.pop_front();
            chk("ld_rdata", ld_rdata, exp);
        end
        ld_valid = 1'b0;
        @(posedge clk);
    endtask

    // Expected ready pattern after reset release with both sides requesting continuously.
    logic [7:0] exp_mem_rdy = 8'b0001_0001;
    logic [7:0] exp_ld_rdy  = 8'b0100_0100;

    initial begin
        resetn = 1'b0;
        mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hA5A5_0008; mem_wstrb = 4'hF;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 22'd9; ld_wdata = 32'h5A5A_0009;
        m_valid = 1'b0; m_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ram_wen", {28'h0, ram_wen}, 32'h0);
        chk("rst_ram_addr", {10'h0, ram_addr}, 32'h0);
        chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);

        resetn = 1'b1;
        #1;
        chk("first_grant_wen", {28'h0, ram_wen}, 32'hF);
        chk("first_grant_addr", {10'h0, ram_addr}, 32'd8);
        model_write(8'd8, 32'hA5A5_0008, 4'hF);
        model_write(8'd9, 32'h5A5A_0009, 4'hF);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr_mem_ready_%0d", k), {31'h0, mem_ready}, {31'h0, exp_mem_rdy[k]});
            chk($sformatf("rr_ld_ready_%0d", k), {31'h0, ld_ready}, {31'h0, exp_ld_rdy[k]});
        end
        mem_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk);

        ld_xfer(22'd8, 1'b0, 32'h0);
        cpu_xfer(32'h24, 32'h0, 4'h0);

        for (int i = 0; i < 256; i++) ld_xfer(i[21:0], 1'b1, i);
        cpu_xfer(32'd37 * 4, 32'h0, 4'h0);
        cpu_xfer(32'h0, 32'h0, 4'h0);
        cpu_xfer(32'd255 * 4, 32'h0, 4'h0);
        ld_xfer(22'd200, 1'b0, 32'h0);

        cpu_xfer(32'h10, 32'hCAFE_BABE, 4'hF);
        cpu_xfer(32'h13, 32'h0, 4'h0);
        cpu_xfer(32'h18, 32'h1122_3344, 4'hF);
        cpu_xfer(32'h18, 32'h00AA_0000, 4'b0100);
        cpu_xfer(32'h18, 32'h0, 4'h0);
        cpu_xfer(32'h18, 32'hDEAD_BEEF, 4'b1010);
        ld_xfer(22'd6, 1'b0, 32'h0);

        @(negedge clk);
        mem_addr = 32'd37 * 4; mem_wstrb = 4'h0; mem_valid = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("abort_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        chk("abort_ram_wen", {28'h0, ram_wen}, 32'h0);
        mem_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;

        @(negedge clk);
        ld_addr = 22'd40; ld_we = 1'b1; ld_wdata = 32'h0000_1234; ld_valid = 1'b1;
        model_write(8'd40, 32'h0000_1234, 4'hF);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("abort_ld_ready", {31'h0, ld_ready}, 32'h0);
        ld_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;
        cpu_xfer(32'd40 * 4, 32'h0, 4'h0);
        cpu_xfer(32'd37 * 4, 32'h0, 4'h0);

        @(negedge clk);
        m_addr = 32'h0000_0008; m_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("miss_ram_wen", {28'h0, m_ram_wen}, 32'h0);
            chk("miss_mem_ready", {31'h0, m_ready}, 32'h0);
            @(negedge clk);
        end
        m_addr = 32'h0001_0008;
        #1;
        chk("hit_ram_wen", {28'h0, m_ram_wen}, 32'hF);
        chk("hit_ram_addr", {10'h0, m_ram_addr}, 32'd2);
        @(posedge clk); #1;
        chk("hit_mem_ready", {31'h0, m_ready}, 32'h1);
        m_valid = 1'b0;
        @(posedge clk); #1;
        chk("hit_ready_pulse", {31'h0, m_ready}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/picosoc_mem_ctrl.md
Name: picosoc_mem_ctrl

Overview:
- Bus front-end that sits directly upstream of the on-chip firmware RAM (byte-laned, synchronous, 1-cycle read latency, 22-bit word address).
- Arbitrates between two requesters: the picorv32 native memory interface, and a boot/debug loader port that writes or reads firmware words.
- Decodes the CPU address window, drives the RAM write-enable, address and data, and returns the ready handshake and read data to the winning requester.

Parameters:
- WORDS, 256, RAM depth in 32-bit words; power of two, 2..2^22. AW = clog2(WORDS).
- BASE_ADDR, 32'h0000_0000, CPU byte address of RAM word 0; aligned to WORDS*4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request valid; held until mem_ready
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  CPU byte strobes; 0 means read
- mem_ready  out  1  CPU handshake, 1-cycle pulse
- mem_rdata  out  32  CPU read data, valid while mem_ready=1
- ld_valid  in  1  loader request valid; held until ld_ready
- ld_we  in  1  loader write (1) or read (0); always a full word
- ld_addr  in  22  loader word address
- ld_wdata  in  32  loader write data
- ld_ready  out  1  loader handshake, 1-cycle pulse
- ld_rdata  out  32  loader read data, valid while ld_ready=1
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  22  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM registered read data

Behaviour:
- Reset: resetn is asynchronous and active-low.
  - On reset: state=IDLE, last_grant=LOADER (so the CPU wins the first tie).
  - mem_ready=0, ld_ready=0, ram_wen=0, mem_rdata=0, ld_rdata=0, ram_addr=0, ram_wdata=0.
- cpu_hit = mem_valid && mem_addr[31:AW+2]==BASE_ADDR[31:AW+2].
  - Misses are ignored: no RAM access, mem_ready stays 0, and another slave answers.
  - mem_addr[1:0] is ignored.
- FSM states IDLE and RESP.
- IDLE:
  - Requests: cpu_hit and ld_valid.
  - Neither request present: ram_wen=0, ram_addr/ram_wdata=0; stay in IDLE.
  - One request present: grant it.
  - Both present: grant the requester that is not last_grant (round-robin).
  - On grant, drive the RAM port combinationally in the same cycle:
    - CPU: ram_addr = zero-extended mem_addr[AW+1:2], ram_wen = mem_wstrb, ram_wdata = mem_wdata.
    - Loader: ram_addr = ld_addr (bits above AW forced to 0), ram_wen = ld_we ? 4'hF : 4'h0, ram_wdata = ld_wdata.
  - Next edge: register grant into cur and last_grant, go to RESP.
- RESP:
  - ram_wen=0; ram_addr holds the registered address of the granted access.
  - Only the granted side sees a ready pulse this cycle:
    - CPU granted: mem_ready=1 and mem_rdata=ram_rdata; ld_ready=0.
    - Loader granted: ld_ready=1 and ld_rdata=ram_rdata; mem_ready=0.
  - For writes, rdata is the RAM's read-during-write value; requesters must not rely on it.
  - Next edge: unconditionally back to IDLE.
- Latency: request seen in cycle N gives ready in cycle N+1 when uncontested. Back-to-back throughput is one access per 2 cycles.
- Data outputs outside RESP:
  - mem_rdata=0 whenever mem_ready=0.
  - ld_rdata=0 whenever ld_ready=0.
- Fairness: a loser keeps its valid asserted and is granted at the next IDLE. Maximum wait for a hit request is 3 cycles to ready.
- Requester obligations: valid must drop, or present a new request, in the cycle after ready.
  - The block does not re-sample valid in RESP.
  - A valid deasserted in RESP is not an error.
- Reset mid-operation: asynchronous return to IDLE.
  - ram_wen drops immediately; no ready pulse is produced for the aborted access.
  - A write already committed at a prior edge stays written.
- Strobe patterns pass through unmodified, including non-contiguous ones such as 4'b1010.

Test Plan:
- Reset: hold resetn=0 with mem_valid=1 and a hit address -> ram_wen=0, mem_ready=0, ld_ready=0. Release resetn -> first access granted in the next cycle.
- CPU write then read, BASE_ADDR=0:
  - Write mem_addr=32'h10, wstrb=4'hF, wdata=32'hCAFEBABE -> ram_addr=4, ram_wen=4'hF in cycle N, mem_ready=1 in N+1.
  - Read back the same address -> mem_rdata=32'hCAFEBABE.
- Byte lane: write wstrb=4'b0100, wdata=32'h00AA0000 over 32'h11223344 -> readback 32'h11AA3344.
- Address miss: BASE_ADDR=32'h0001_0000, mem_addr=32'h0000_0008 -> no ram_wen, mem_ready stays 0 for 10 cycles.
- Contention: mem_valid (hit) and ld_valid asserted together from reset, held until ready -> grants CPU, loader, CPU, loader alternately; each ready pulse is exactly 1 cycle.
- Loader boot: ld_we=1 writes words 0..255 with data=index; readback via the CPU -> word 37 returns 32'h25. An async reset pulsed in RESP suppresses that cycle's ready.
